// File: rtl/cla_slice_add_ctrl.sv
// cla_slice_add_ctrl: multi-cycle add/subtract sequencer that reuses one
// 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
// Carry between nibbles is held in a register. Start/done handshake.
// Optional zero/neg flags are built when CLA_SLICE_ADD_CTRL_FLAGS_EN is defined;
// otherwise zero and neg are constant 0.
module cla_slice_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       c;
  logic [3:0]       nib_sum;
  logic             last;
  logic             accept;

  // Handshake outputs decode straight from the state register.
  assign ready  = (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign accept = start && (state != S_RUN);
  assign last   = (idx == IW'(NSLICE - 1));

  // Shared 4-bit CLA slice on nibble idx, and the accumulator with that nibble merged in.
  always_comb begin
    nib_a    = opa[{idx, 2'b00} +: 4];
    nib_b    = opb[{idx, 2'b00} +: 4];
    g        = nib_a & nib_b;
    p        = nib_a ^ nib_b;
    c[0]     = carry;
    c[1]     = g[0] | (p[0] & c[0]);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum  = p ^ c[3:0];
    acc_next = acc;
    acc_next[{idx, 2'b00} +: 4] = nib_sum;
  end

  // Next-state logic: IDLE/DONE accept a start, RUN walks the nibbles.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
        else       state_next = S_IDLE;
      end
      S_RUN: begin
        if (last) state_next = S_DONE;
        else      state_next = S_RUN;
      end
      S_DONE: begin
        if (start) state_next = S_RUN;
        else       state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Operand latch, nibble sequencing and final result/carry/overflow capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa    <= {WIDTH{1'b0}};
      opb    <= {WIDTH{1'b0}};
      acc    <= {WIDTH{1'b0}};
      carry  <= 1'b0;
      idx    <= {IW{1'b0}};
      result <= {WIDTH{1'b0}};
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert b once here and seed the carry.
      opa   <= a;
      opb   <= op_sub ? ~b : b;
      carry <= op_sub;
      idx   <= {IW{1'b0}};
    end else if (state == S_RUN) begin
      acc   <= acc_next;
      carry <= c[4];
      idx   <= idx + IW'(1);
      if (last) begin
        result <= acc_next;
        co     <= c[4];
        // c[3] of the top nibble is the carry into bit WIDTH-1.
        ovf    <= c[3] ^ c[4];
      end
    end
  end

`ifdef CLA_SLICE_ADD_CTRL_FLAGS_EN
  // Zero/negative flags captured with the final result.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if ((state == S_RUN) && last) begin
      zero <= (acc_next == {WIDTH{1'b0}});
      neg  <= acc_next[WIDTH-1];
    end
  end
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_slice_add_ctrl.sv
// Scoreboard bench for cla_slice_add_ctrl: 32-bit and 8-bit instances,
// directed vectors with hand-computed results, monitors compare on done.
module tb_cla_slice_add_ctrl;

  localparam bit FLAGS =
`ifdef CLA_SLICE_ADD_CTRL_FLAGS_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32;
  exp_t        e8;

  logic        start32 = 1'b0, op32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, busy32, done32, co32, ovf32, zero32, neg32;
  logic [31:0] result32;

  logic        start8 = 1'b0, op8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8, co8, ovf8, zero8, neg8;
  logic [7:0]  result8;

  cla_slice_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op_sub(op32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .result(result32),
    .co(co32), .ovf(ovf32), .zero(zero32), .neg(neg32)
  );

  cla_slice_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op_sub(op8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(result8),
    .co(co8), .ovf(ovf8), .zero(zero8), .neg(neg8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 32-bit monitor: pop expected entry on each done pulse.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        check("done32_unexpected", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        check("result32", result32, e32.res);
        check("co32", co32, e32.co);
        check("ovf32", ovf32, e32.ovf);
        check("zero32", zero32, FLAGS ? (e32.res == 32'd0) : 1'b0);
        check("neg32", neg32, FLAGS ? e32.res[31] : 1'b0);
        check("latency32", cyc, e32.cyc);
      end
    end
  end

  // 8-bit monitor.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("result8", result8, e8.res[7:0]);
        check("co8", co8, e8.co);
        check("ovf8", ovf8, e8.ovf);
        check("zero8", zero8, FLAGS ? (e8.res[7:0] == 8'd0) : 1'b0);
        check("neg8", neg8, FLAGS ? e8.res[7] : 1'b0);
        check("latency8", cyc, e8.cyc);
      end
    end
  end

  task automatic issue32(logic [31:0] x, logic [31:0] y, logic s,
                         logic [31:0] r, logic c, logic o, bit push);
    exp_t e;
    @(negedge clk);
    a32 = x; b32 = y; op32 = s; start32 = 1'b1;
    if (push) begin
      e.res = r; e.co = c; e.ovf = o; e.cyc = cyc + 1 + 8;
      q32.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic issue8(logic [7:0] x, logic [7:0] y, logic s,
                        logic [7:0] r, logic c, logic o);
    exp_t e;
    @(negedge clk);
    a8 = x; b8 = y; op8 = s; start8 = 1'b1;
    e.res = {24'd0, r}; e.co = c; e.ovf = o; e.cyc = cyc + 1 + 2;
    q8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Scribble on inputs during RUN; checks that result still holds prev.
  task automatic noise32(logic [31:0] prev);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; op32 = k[0]; start32 = k[1];
      if (k == 3) check("hold32", result32, prev);
      @(posedge clk);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    @(posedge clk);
    check("drain", q32.size() + q8.size(), 0);
  endtask

  initial begin
    int nb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready32, 1'b1);
    check("rst_busy", busy32, 1'b0);
    check("rst_done", done32, 1'b0);
    check("rst_result", result32, 32'd0);
    check("rst_flags", {co32, ovf32, zero32, neg32}, 4'd0);
    check("rst_ready8", ready8, 1'b1);
    reset = 1'b0;

    // Wrap to zero.
    issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("run_busy", busy32, 1'b1);
    check("run_ready", ready32, 1'b0);
    start32 = 1'b0;
    nb = 0;
    repeat (12) begin
      if (busy32) nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, 8);
    drain();

    // Signed overflow on add, then a borrowing subtract.
    issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    @(negedge clk); start32 = 1'b0;
    drain();
    issue32(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start32 = 1'b0;
    drain();

    // Back-to-back with start held high; input noise during RUN.
    issue32(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    noise32(32'hFFFF_FFFE);
    issue32(32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b1);
    noise32(32'h0000_0003);
    issue32(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start32 = 1'b0;
    drain();

    // Reset mid-operation aborts without a done pulse.
    issue32(32'h1234_5678, 32'h1111_1111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start32 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", ready32, 1'b1);
    check("abort_busy", busy32, 1'b0);
    check("abort_done", done32, 1'b0);
    check("abort_result", result32, 32'd0);
    check("abort_flags", {co32, ovf32, zero32, neg32}, 4'd0);
    reset = 1'b0;
    issue32(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start32 = 1'b0;
    drain();

    // 8-bit instance.
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain();
    issue8(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
